// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, free-running 16x oversampling
// tick generator and a frame-decode FSM presenting bytes with a done strobe.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_MID    = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);

    generate
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("uart_rx: OVERSAMPLE must be even and >= 8");
        end
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx: CLK_FREQ too low for BAUD*OVERSAMPLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic             r_sync1, r_sync2;
    logic [DIV_W-1:0] r_div;
    logic             r_rx_prev;
    state_t           r_state;
    logic [S_W-1:0]   r_s_cnt;
    logic [2:0]       r_b_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_done;
    logic             r_busy;
    logic             r_ferr;

    logic             w_rx_s;
    logic             w_tick;
    state_t           w_state_nxt;
    logic [S_W-1:0]   w_s_cnt_nxt;
    logic [2:0]       w_b_cnt_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_good;
    logic             w_bad;

    assign w_rx_s = r_sync2;
    assign w_tick = (r_div == DIV_LAST);

    // Synchronizer resets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running: frame timing is taken relative to the detected edge, not the counter phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_prev <= 1'b1;
        end else if (w_tick) begin
            r_rx_prev <= w_rx_s;
        end
    end

    // FSM state register, with the counters and shift register it steers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_s_cnt <= '0;
            r_b_cnt <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s_cnt <= w_s_cnt_nxt;
            r_b_cnt <= w_b_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_cnt_nxt = r_s_cnt;
        w_b_cnt_nxt = r_b_cnt;
        w_shift_nxt = r_shift;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        w_state_nxt = START;
                        w_s_cnt_nxt = '0;
                    end
                end
                START: begin
                    if (r_s_cnt == S_MID) begin
                        if (!w_rx_s) begin
                            w_state_nxt = DATA;
                            w_s_cnt_nxt = '0;
                            w_b_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_s_cnt == S_LAST) begin
                        w_s_cnt_nxt = '0;
                        w_shift_nxt = {w_rx_s, r_shift[7:1]};
                        if (r_b_cnt == 3'd7) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_b_cnt_nxt = r_b_cnt + 1'b1;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_s_cnt == S_LAST) begin
                        w_s_cnt_nxt = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_good = 1'b0;
        w_bad  = 1'b0;
        if (w_tick && r_state == STOP && r_s_cnt == S_LAST) begin
            w_good = w_rx_s;
            w_bad  = !w_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data <= 8'h00;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_done <= w_good;
            if (w_good) begin
                r_rx_data <= r_shift;
                r_ferr    <= 1'b0;
            end else if (w_bad) begin
                r_ferr    <= 1'b1;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_done;
    assign rx_busy   = r_busy;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized 8N1 traffic
// with baud skew, compared against a byte-level model of the line protocol.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int CLK_NS   = 10;
    localparam int BIT_NS   = CLK_NS * (CLK_FREQ / (BAUD * OS)) * OS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
    );

    always #(CLK_NS/2) clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: records every delivered byte and protocol-shape violations.
    logic [7:0] got_q[$];
    int         mon_wide = 0, mon_busy_bad = 0;
    int         busy_len = 0, last_busy_len = 0, busy_starts = 0;
    realtime    t_done = 0;
    logic       done_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_done) begin
            got_q.push_back(rx_data);
            t_done = $realtime;
            if (done_prev) mon_wide++;
            if (rx_busy || !busy_prev) mon_busy_bad++;
        end
        if (rx_busy) begin
            if (!busy_prev) busy_starts++;
            busy_len++;
        end else if (busy_prev) begin
            last_busy_len = busy_len;
            busy_len = 0;
        end
        done_prev = rx_done;
        busy_prev = rx_busy;
    end

    // Reference model: last good byte, error flag, queue of expected deliveries.
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic       exp_ferr  = 1'b0;

    task automatic send_byte(input logic [7:0] b, input logic stop, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns * 9 / 10);
        if (stop) begin
            exp_q.push_back(b);
            last_good = b;
            exp_ferr  = 1'b0;
        end else begin
            exp_ferr  = 1'b1;
        end
        chk("rx_data", rx_data, last_good);
        chk("frame_err", frame_err, exp_ferr);
        chk("done_count", got_q.size(), exp_q.size());
        #(bit_ns - bit_ns * 9 / 10);
        if (!stop) begin
            rx = 1'b1;
            #(bit_ns);
        end
    endtask

    initial begin
        realtime t0, dl;
        int      s0, n0, bit_ns;
        logic [7:0] b;
        logic       stp;

        #20 rst = 1'b0;
        #100;
        chk("rst_data", rx_data, 8'h00);
        chk("rst_busy", rx_busy, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_done", rx_done, 1'b0);
        rst = 1'b1;
        #(BIT_NS * 20);
        chk("idle_data", rx_data, 8'h00);
        chk("idle_busy", rx_busy, 1'b0);
        chk("idle_no_done", got_q.size(), 0);

        t0 = $realtime;
        send_byte(8'h30, 1'b1, BIT_NS);
        dl = t_done - t0;
        chk("done_latency", (dl >= 9.5 * BIT_NS) && (dl <= 9.5 * BIT_NS + 300.0), 1'b1);
        #(BIT_NS);

        s0 = busy_starts;
        n0 = got_q.size();
        rx = 1'b0;
        #300;
        rx = 1'b1;
        #(BIT_NS * 2);
        chk("glitch_seen", busy_starts - s0, 1);
        chk("glitch_busy_short", last_busy_len < (BIT_NS * 6 / 10) / CLK_NS, 1'b1);
        chk("glitch_no_done", got_q.size(), n0);
        chk("glitch_data", rx_data, last_good);

        send_byte(8'hA5, 1'b0, BIT_NS);
        send_byte(8'h5A, 1'b1, BIT_NS);
        #(BIT_NS);

        send_byte(8'h55, 1'b1, BIT_NS);
        send_byte(8'hAA, 1'b1, BIT_NS);
        #(BIT_NS);
        send_byte(8'h55, 1'b1, BIT_NS * 102 / 100);
        send_byte(8'hAA, 1'b1, BIT_NS * 102 / 100);
        #(BIT_NS);

        for (int k = 0; k < 24; k++) begin
            b      = 8'($urandom);
            stp    = ($urandom_range(0, 5) != 0);
            bit_ns = BIT_NS * int'($urandom_range(98, 102)) / 100;
            send_byte(b, stp, bit_ns);
            if ($urandom_range(0, 1) != 0) #($urandom_range(1, 3) * BIT_NS / 2);
        end
        #(BIT_NS);

        // Abort a frame during data bit 3; outputs must clear without a clock edge.
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx = ~rx;
            #(BIT_NS);
        end
        #(BIT_NS / 2);
        rst = 1'b0;
        #1;
        chk("abort_busy", rx_busy, 1'b0);
        chk("abort_data", rx_data, 8'h00);
        chk("abort_ferr", frame_err, 1'b0);
        rx = 1'b1;
        #(BIT_NS * 3);
        rst = 1'b1;
        last_good = 8'h00;
        exp_ferr  = 1'b0;
        #(BIT_NS * 2);
        chk("abort_no_done", got_q.size(), exp_q.size());
        send_byte(8'hC3, 1'b1, BIT_NS);
        #(BIT_NS);

        send_byte(8'h30, 1'b1, BIT_NS);
        #(BIT_NS * 2);

        chk("total_bytes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("byte_seq", got_q[i], exp_q[i]);
        chk("done_1clk_violations", mon_wide, 0);
        chk("busy_at_done_violations", mon_busy_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
